// File: rtl/fpadd_sub_arbiter_if.sv
// Issue/response bundle between the FP requesters, the shared add/sub datapath and the arbiter.
// The slave modport is the arbiter's view; master is the requester/datapath side.
interface fpadd_sub_arbiter_if #(
  parameter int NREQ = 4
);
  logic                   hold;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_sub;
  logic [32*NREQ-1:0]     req_a;
  logic [32*NREQ-1:0]     req_b;
  logic                   fp_sub;
  logic [31:0]            fp_a;
  logic [31:0]            fp_b;
  logic [31:0]            fp_res;
  logic [NREQ-1:0]        rsp_valid;
  logic [31:0]            rsp_data;
  logic                   busy;

  modport slave (
    input  hold, req_valid, req_sub, req_a, req_b, fp_res,
    output req_ready, fp_sub, fp_a, fp_b, rsp_valid, rsp_data, busy
  );

  modport master (
    output hold, req_valid, req_sub, req_a, req_b, fp_res,
    input  req_ready, fp_sub, fp_a, fp_b, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/fpadd_sub_arbiter.sv
// Round-robin sharing of one pipelined FP add/sub among NREQ requesters; result returns LAT+1 cycles
// after the handshake. Grant is suppressed by hold; responses have no backpressure.
module fpadd_sub_arbiter #(
  parameter int NREQ = 4,
  parameter int TAGW = 2,
  parameter int LAT  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  fpadd_sub_arbiter_if.slave    bus
);

  logic [TAGW-1:0] r_last;
  logic [TAGW-1:0] w_gidx;
  logic            w_found;
  logic [NREQ-1:0] w_grant;
  logic            w_hs;

  logic            r_iss_v;
  logic [TAGW-1:0] r_iss_tag;
  logic [31:0]     r_fp_a;
  logic [31:0]     r_fp_b;
  logic            r_fp_sub;

  logic [LAT:1]    r_slot_v;
  logic [TAGW-1:0] r_slot_tag [1:LAT];
  logic [NREQ-1:0] w_rsp_valid;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(r_last) + k) % NREQ;
      if (!w_found && bus.req_valid[idx]) begin
        w_found = 1'b1;
        w_gidx  = TAGW'(idx);
      end
    end
  end

  // Reset gates the grant so req_ready reads zero while rst is low.
  always_comb begin
    w_grant = '0;
    if (w_found && !bus.hold && rst) begin
      w_grant[w_gidx] = 1'b1;
    end
  end

  assign w_hs = |w_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last    <= TAGW'(NREQ - 1);
      r_iss_v   <= 1'b0;
      r_iss_tag <= '0;
      r_fp_a    <= '0;
      r_fp_b    <= '0;
      r_fp_sub  <= 1'b0;
    end else begin
      r_iss_v <= w_hs;
      if (w_hs) begin
        r_last    <= w_gidx;
        r_iss_tag <= w_gidx;
        r_fp_a    <= bus.req_a[32*w_gidx +: 32];
        r_fp_b    <= bus.req_b[32*w_gidx +: 32];
        r_fp_sub  <= bus.req_sub[w_gidx];
      end
    end
  end

  // Owner tags ride alongside the free-running datapath; bubbles carry v=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot_v <= '0;
      for (int k = 1; k <= LAT; k++) begin
        r_slot_tag[k] <= '0;
      end
    end else begin
      r_slot_v[1]   <= r_iss_v;
      r_slot_tag[1] <= r_iss_tag;
      for (int k = 2; k <= LAT; k++) begin
        r_slot_v[k]   <= r_slot_v[k-1];
        r_slot_tag[k] <= r_slot_tag[k-1];
      end
    end
  end

  always_comb begin
    w_rsp_valid = '0;
    for (int j = 0; j < NREQ; j++) begin
      w_rsp_valid[j] = r_slot_v[LAT] && (r_slot_tag[LAT] == TAGW'(j));
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.fp_a      = r_fp_a;
  assign bus.fp_b      = r_fp_b;
  assign bus.fp_sub    = r_fp_sub;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = bus.fp_res;
  assign bus.busy      = r_iss_v | (|r_slot_v);

endmodule

// File: tb/tb_fpadd_sub_arbiter.sv
// Directed bench: arbiter plus a table-driven LAT-stage stand-in for the FP add/sub datapath.
module tb_fpadd_sub_arbiter;
  localparam int NREQ = 4;
  localparam int TAGW = 2;
  localparam int LAT  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  fpadd_sub_arbiter_if #(.NREQ(NREQ)) bus ();

  fpadd_sub_arbiter #(.NREQ(NREQ), .TAGW(TAGW), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: known operand pairs only, anything else yields a quiet NaN.
  function automatic logic [31:0] fpop(input logic [64:0] op);
    logic [31:0] a, b;
    logic        s;
    s = op[64];
    a = op[63:32];
    b = op[31:0];
    if (!s && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (!s && a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
    if ( s && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
    if ( s && a == 32'h40800000 && b == 32'h3F800000) return 32'h40400000;
    return 32'h7FC00000;
  endfunction

  logic [64:0] dp [LAT];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) dp[i] <= '0;
    end else begin
      dp[0] <= {bus.fp_sub, bus.fp_a, bus.fp_b};
      for (int i = 1; i < LAT; i++) dp[i] <= dp[i-1];
    end
  end
  assign bus.fp_res = fpop(dp[LAT-1]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.req_a[i*32 +: 32] = a;
    bus.req_b[i*32 +: 32] = b;
    bus.req_sub[i]        = s;
  endtask

  task automatic set_all_ops();
    set_op(0, 32'h3F800000, 32'h40000000, 1'b0);
    set_op(1, 32'h40000000, 32'h40000000, 1'b0);
    set_op(2, 32'h40400000, 32'h3F800000, 1'b1);
    set_op(3, 32'h40800000, 32'h3F800000, 1'b1);
  endtask

  // Leaves the bench in cycle 0 just after reset release, inputs idle.
  task automatic do_reset();
    rst           = 1'b0;
    bus.hold      = 1'b0;
    bus.req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  logic [31:0] rdy_exp;
  logic [31:0] rsp_exp;
  logic [31:0] fair_res [NREQ];

  initial begin
    bus.hold      = 1'b0;
    bus.req_valid = '0;
    bus.req_sub   = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    fair_res[0] = 32'h40400000;
    fair_res[1] = 32'h40800000;
    fair_res[2] = 32'h40000000;
    fair_res[3] = 32'h40400000;

    // Reset values, with a request pending to show the grant is gated.
    bus.req_valid = 4'b0001;
    #2;
    chk("rst_ready",  32'(bus.req_ready), 32'h0);
    chk("rst_fp_a",   bus.fp_a,           32'h0);
    chk("rst_fp_b",   bus.fp_b,           32'h0);
    chk("rst_fp_sub", 32'(bus.fp_sub),    32'h0);
    chk("rst_rsp",    32'(bus.rsp_valid), 32'h0);
    chk("rst_busy",   32'(bus.busy),      32'h0);
    do_reset();

    // Single add from requester 0.
    set_all_ops();
    bus.req_valid = 4'b0001;
    #1;
    chk("add_ready", 32'(bus.req_ready), 32'h1);
    chk("add_busy0", 32'(bus.busy), 32'h0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      bus.req_valid = '0;
      #1;
      chk($sformatf("add_rsp_c%0d", c), 32'(bus.rsp_valid), (c == 4) ? 32'h1 : 32'h0);
      chk($sformatf("add_busy_c%0d", c), 32'(bus.busy), (c <= 4) ? 32'h1 : 32'h0);
      if (c == 1) begin
        chk("add_fp_a",   bus.fp_a, 32'h3F800000);
        chk("add_fp_b",   bus.fp_b, 32'h40000000);
        chk("add_fp_sub", 32'(bus.fp_sub), 32'h0);
      end
      if (c == 4) chk("add_data", bus.rsp_data, 32'h40400000);
    end

    // Single subtract from requester 2.
    tick();
    bus.req_valid = 4'b0100;
    #1;
    chk("sub_ready", 32'(bus.req_ready), 32'h4);
    for (int c = 1; c <= 5; c++) begin
      tick();
      bus.req_valid = '0;
      #1;
      chk($sformatf("sub_rsp_c%0d", c), 32'(bus.rsp_valid), (c == 4) ? 32'h4 : 32'h0);
      if (c == 1) chk("sub_fp_sub", 32'(bus.fp_sub), 32'h1);
      if (c == 4) chk("sub_data", bus.rsp_data, 32'h40000000);
    end

    // Round-robin with all four requesting from reset.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      bus.req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      rdy_exp = (k < 8) ? (32'h1 << (k % 4)) : 32'h0;
      rsp_exp = (k >= 4) ? (32'h1 << ((k - 4) % 4)) : 32'h0;
      chk($sformatf("rr_ready_c%0d", k), 32'(bus.req_ready), rdy_exp);
      chk($sformatf("rr_rsp_c%0d", k),   32'(bus.rsp_valid), rsp_exp);
      if (k >= 4) chk($sformatf("rr_data_c%0d", k), bus.rsp_data, fair_res[(k - 4) % 4]);
    end

    // Hold blocks new grants while two accepted ops drain.
    for (int k = 0; k < 8; k++) begin
      tick();
      bus.hold      = (k >= 2);
      bus.req_valid = (k <= 6) ? 4'b0010 : 4'b0000;
      #1;
      chk($sformatf("hold_ready_c%0d", k), 32'(bus.req_ready), (k < 2) ? 32'h2 : 32'h0);
      chk($sformatf("hold_rsp_c%0d", k), 32'(bus.rsp_valid), (k == 4 || k == 5) ? 32'h2 : 32'h0);
      chk($sformatf("hold_busy_c%0d", k), 32'(bus.busy), (k >= 1 && k <= 5) ? 32'h1 : 32'h0);
      if (k == 4 || k == 5) chk($sformatf("hold_data_c%0d", k), bus.rsp_data, 32'h40800000);
    end
    bus.hold      = 1'b0;
    bus.req_valid = '0;

    // Reset in the middle of two in-flight ops.
    for (int k = 0; k < 2; k++) begin
      tick();
      bus.req_valid = 4'b0010;
      #1;
      chk($sformatf("mid_ready_c%0d", k), 32'(bus.req_ready), 32'h2);
    end
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_ready",  32'(bus.req_ready), 32'h0);
    chk("mid_rst_fp_a",   bus.fp_a,           32'h0);
    chk("mid_rst_fp_b",   bus.fp_b,           32'h0);
    chk("mid_rst_fp_sub", 32'(bus.fp_sub),    32'h0);
    chk("mid_rst_rsp",    32'(bus.rsp_valid), 32'h0);
    chk("mid_rst_busy",   32'(bus.busy),      32'h0);
    bus.req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    for (int m = 0; m < 6; m++) begin
      tick();
      chk($sformatf("post_rst_rsp_%0d", m),  32'(bus.rsp_valid), 32'h0);
      chk($sformatf("post_rst_busy_%0d", m), 32'(bus.busy), 32'h0);
    end
    tick();
    bus.req_valid = 4'b0011;
    #1;
    chk("post_rst_first_grant", 32'(bus.req_ready), 32'h1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      bus.req_valid = '0;
      #1;
      chk($sformatf("post_rst_resp_c%0d", c), 32'(bus.rsp_valid), (c == 4) ? 32'h1 : 32'h0);
    end

    // Sparse traffic with bubbles.
    for (int k = 0; k <= 10; k++) begin
      tick();
      bus.req_valid = (k == 0 || k == 5) ? 4'b1000 : ((k == 1) ? 4'b0010 : 4'b0000);
      #1;
      rdy_exp = 32'(bus.req_valid);
      rsp_exp = (k == 4 || k == 9) ? 32'h8 : ((k == 5) ? 32'h2 : 32'h0);
      chk($sformatf("sparse_ready_c%0d", k), 32'(bus.req_ready), rdy_exp);
      chk($sformatf("sparse_rsp_c%0d", k),   32'(bus.rsp_valid), rsp_exp);
      if (k == 4 || k == 9) chk($sformatf("sparse_data_c%0d", k), bus.rsp_data, 32'h40400000);
      if (k == 5)           chk("sparse_data_c5", bus.rsp_data, 32'h40800000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
